// File: rtl/pb_boot_pkg.sv
// Shared constants and state encoding for the PicoBlaze UART boot loader.
// The word packer lives here so the loader and any future tools agree on byte order.
package pb_boot_pkg;

   localparam int unsigned ADDR_W        = 10;
   localparam int unsigned WORD_W        = 18;
   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LEN_HI = 3'd1;
   localparam state_t ST_LEN_LO = 3'd2;
   localparam state_t ST_DATA   = 3'd3;
   localparam state_t ST_CSUM   = 3'd4;
   localparam state_t ST_FAIL   = 3'd5;

   function automatic logic [WORD_W-1:0] pack_word(input logic [1:0] b0_lo,
                                                   input logic [7:0] b1,
                                                   input logic [7:0] b2);
      return {b0_lo, b1, b2};
   endfunction

endpackage

// File: rtl/pb_boot_timer.sv
// Inter-byte gap counter: pulses expired after CYCLES consecutive enabled cycles
// with no restart.
module pb_boot_timer #(
   parameter int unsigned CYCLES = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int unsigned   CW   = (CYCLES < 2) ? 1 : $clog2(CYCLES);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] cnt;

   // cnt holds the number of quiet cycles already seen, so the CYCLES-th one fires
   assign expired = enable && !restart && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!enable || restart || expired) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pb_boot_ctrl.sv
// UART boot loader: receives a SYNC/length/data/checksum frame and writes
// 18-bit words into PicoBlaze program memory while holding the CPU in reset.
module pb_boot_ctrl
   import pb_boot_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5000000,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_data,
   output logic              mem_we,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_t            state;
   logic [7:0]        sum;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W-1:0] last_idx;
   logic [1:0]        byte_idx;
   logic [1:0]        b0_hold;
   logic [7:0]        b1_hold;
   logic              timer_en;
   logic              timer_exp;

   assign timer_en = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                     (state == ST_DATA)   || (state == ST_CSUM);
   assign busy     = (state != ST_IDLE);

   pb_boot_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (rx_valid),
      .enable  (timer_en),
      .expired (timer_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sum       <= '0;
         word_idx  <= '0;
         last_idx  <= '0;
         byte_idx  <= '0;
         b0_hold   <= '0;
         b1_hold   <= '0;
         mem_addr  <= '0;
         mem_data  <= '0;
         mem_we    <= 1'b0;
         cpu_reset <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            // FAIL differs from IDLE only in holding busy/error/cpu_reset high
            ST_IDLE, ST_FAIL: begin
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  state     <= ST_LEN_HI;
                  error     <= 1'b0;
                  sum       <= '0;
                  cpu_reset <= 1'b1;
               end
            end
            ST_LEN_HI: begin
               if (timer_exp) begin
                  state <= ST_FAIL;
                  error <= 1'b1;
               end else if (rx_valid) begin
                  last_idx[ADDR_W-1:8] <= rx_data[1:0];
                  sum                  <= sum + rx_data;
                  state                <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (timer_exp) begin
                  state <= ST_FAIL;
                  error <= 1'b1;
               end else if (rx_valid) begin
                  last_idx[7:0] <= rx_data;
                  sum           <= sum + rx_data;
                  word_idx      <= '0;
                  byte_idx      <= '0;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (timer_exp) begin
                  state <= ST_FAIL;
                  error <= 1'b1;
               end else if (rx_valid) begin
                  sum <= sum + rx_data;
                  case (byte_idx)
                     2'd0: begin
                        b0_hold  <= rx_data[1:0];
                        byte_idx <= 2'd1;
                     end
                     2'd1: begin
                        b1_hold  <= rx_data;
                        byte_idx <= 2'd2;
                     end
                     default: begin
                        mem_we   <= 1'b1;
                        mem_addr <= word_idx;
                        mem_data <= pack_word(b0_hold, b1_hold, rx_data);
                        byte_idx <= 2'd0;
                        if (word_idx == last_idx) begin
                           state <= ST_CSUM;
                        end else begin
                           word_idx <= word_idx + ADDR_W'(1);
                        end
                     end
                  endcase
               end
            end
            ST_CSUM: begin
               if (timer_exp) begin
                  state <= ST_FAIL;
                  error <= 1'b1;
               end else if (rx_valid) begin
                  if (rx_data == sum) begin
                     state     <= ST_IDLE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     state <= ST_FAIL;
                     error <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pb_boot_ctrl.sv
// Self-checking bench for pb_boot_ctrl: a frame-position reference model is
// compared against the DUT every cycle, plus literal checks on known frames.
module tb_pb_boot_ctrl;

   localparam int unsigned TO   = 40;
   localparam logic [7:0]  SYNC = 8'hA5;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_valid = 1'b0;
   logic [9:0]  mem_addr;
   logic [17:0] mem_data;
   logic        mem_we;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;

   pb_boot_ctrl #(
      .TIMEOUT_CYCLES (TO),
      .SYNC_BYTE      (SYNC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_we    (mem_we),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame position arithmetic) ----------------
   bit          m_active;
   bit          m_err;
   bit          m_we;
   bit          m_done;
   logic [9:0]  m_addr;
   logic [17:0] m_data;
   int unsigned pos;
   int unsigned nwords;
   int unsigned gap;
   logic [7:0]  m_sum;
   logic [7:0]  m_lenhi;
   logic [7:0]  m_b0;
   logic [7:0]  m_b1;

   task automatic model_reset();
      m_active = 0; m_err = 0; m_we = 0; m_done = 0;
      m_addr = '0; m_data = '0; pos = 0; nwords = 0; gap = 0;
      m_sum = '0; m_lenhi = '0; m_b0 = '0; m_b1 = '0;
   endtask

   task automatic model_step();
      int unsigned k;
      m_we   = 0;
      m_done = 0;
      if (!m_active) begin
         if (rx_valid && rx_data == SYNC) begin
            m_active = 1; m_err = 0; pos = 0; m_sum = '0; gap = 0;
         end
      end else if (rx_valid) begin
         gap = 0;
         if (pos == 0) begin
            m_lenhi = rx_data;
            m_sum   = m_sum + rx_data;
         end else if (pos == 1) begin
            nwords = int'({m_lenhi[1:0], rx_data}) + 1;
            m_sum  = m_sum + rx_data;
         end else if (pos < 2 + 3 * nwords) begin
            k     = pos - 2;
            m_sum = m_sum + rx_data;
            if (k % 3 == 0) m_b0 = rx_data;
            else if (k % 3 == 1) m_b1 = rx_data;
            else begin
               m_we   = 1;
               m_addr = 10'(k / 3);
               m_data = {m_b0[1:0], m_b1, rx_data};
            end
         end else begin
            m_active = 0;
            if (rx_data == m_sum) m_done = 1;
            else m_err = 1;
         end
         pos++;
      end else begin
         gap++;
         if (gap == TO) begin
            m_active = 0;
            m_err    = 1;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare and write capture ----------------
   logic [17:0] dut_mem [1024];
   int unsigned wr_count   = 0;
   int unsigned done_count = 0;

   initial begin
      forever begin
         @(negedge clk);
         check("mem_we",    32'(mem_we),    32'(m_we));
         check("done",      32'(done),      32'(m_done));
         check("error",     32'(error),     32'(m_err));
         check("busy",      32'(busy),      32'(m_active || m_err));
         check("cpu_reset", 32'(cpu_reset), 32'(m_active || m_err));
         check("mem_addr",  32'(mem_addr),  32'(m_addr));
         check("mem_data",  32'(mem_data),  32'(m_data));
         if (mem_we) begin
            dut_mem[mem_addr] = mem_data;
            wr_count++;
         end
         if (done) done_count++;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] frame_q [$];

   task automatic send_byte(input logic [7:0] b, input int unsigned gap_cycles);
      repeat (gap_cycles) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_queue(input int unsigned maxgap, input int stall_at);
      for (int i = 0; i < frame_q.size(); i++) begin
         if (i == stall_at) send_byte(frame_q[i], TO + $urandom_range(0, 5));
         else send_byte(frame_q[i], $urandom_range(0, maxgap));
      end
   endtask

   task automatic build_frame(input logic [7:0] lh, input logic [7:0] ll, input bit bad);
      int unsigned n;
      logic [7:0]  s;
      logic [7:0]  b;
      n = int'({lh[1:0], ll}) + 1;
      frame_q.delete();
      frame_q.push_back(SYNC);
      frame_q.push_back(lh);
      frame_q.push_back(ll);
      s = lh + ll;
      for (int unsigned i = 0; i < 3 * n; i++) begin
         b = 8'($urandom);
         frame_q.push_back(b);
         s = s + b;
      end
      frame_q.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
   endtask

   task automatic load_frame_a(input logic [7:0] csum);
      frame_q.delete();
      frame_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h34, 8'h56, 8'h01, 8'hAB, 8'hCD, csum};
   endtask

   // ---------------- main sequence ----------------
   int unsigned d0;
   int unsigned w0;
   int unsigned errs;
   logic [17:0] exp_word;

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset busy", 32'(busy), 0);
      check("reset cpu_reset", 32'(cpu_reset), 0);
      check("reset error", 32'(error), 0);
      check("reset mem_addr", 32'(mem_addr), 0);

      // non-SYNC bytes while idle
      send_byte(8'h00, 1);
      send_byte(8'h5A, 1);
      send_byte(8'hFF, 1);
      @(negedge clk);
      check("idle junk busy", 32'(busy), 0);
      check("idle junk cpu_reset", 32'(cpu_reset), 0);

      // two-word frame, checksum = 00+01+02+34+56+01+AB+CD mod 256 = 06
      d0 = done_count; w0 = wr_count;
      load_frame_a(8'h06);
      send_queue(2, -1);
      repeat (3) @(negedge clk);
      check("frameA word0", 32'(dut_mem[0]), 32'h23456);
      check("frameA word1", 32'(dut_mem[1]), 32'h1ABCD);
      check("frameA writes", wr_count - w0, 2);
      check("frameA done", done_count - d0, 1);
      check("frameA cpu_reset", 32'(cpu_reset), 0);
      check("frameA error", 32'(error), 0);

      // same frame, wrong checksum
      d0 = done_count; w0 = wr_count;
      load_frame_a(8'h0F);
      send_queue(2, -1);
      repeat (3) @(negedge clk);
      check("badsum writes", wr_count - w0, 2);
      check("badsum done", done_count - d0, 0);
      check("badsum error", 32'(error), 1);
      check("badsum cpu_reset", 32'(cpu_reset), 1);
      check("badsum busy", 32'(busy), 1);

      // stall after B1 of word 0, then a good frame recovers
      frame_q = '{8'hA5, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
      send_queue(1, 5);
      repeat (3) @(negedge clk);
      check("timeout error", 32'(error), 1);
      check("timeout busy", 32'(busy), 1);
      d0 = done_count;
      load_frame_a(8'h06);
      send_queue(2, -1);
      repeat (3) @(negedge clk);
      check("recover done", done_count - d0, 1);
      check("recover error", 32'(error), 0);

      // maximum length frame
      d0 = done_count; w0 = wr_count;
      build_frame(8'hFF, 8'hFF, 1'b0);
      send_queue(1, -1);
      repeat (3) @(negedge clk);
      check("max writes", wr_count - w0, 1024);
      check("max done", done_count - d0, 1);
      errs = 0;
      for (int unsigned i = 0; i < 1024; i++) begin
         exp_word = {frame_q[3 + 3 * i][1:0], frame_q[4 + 3 * i], frame_q[5 + 3 * i]};
         if (dut_mem[i] !== exp_word) errs++;
      end
      check("max contents", errs, 0);

      // randomized frames: junk, bad checksums, stalls, SYNC inside data
      for (int f = 0; f < 30; f++) begin
         logic [7:0] junk;
         int         stall;
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
            junk = 8'($urandom);
            if (junk == SYNC) junk = 8'h5A;
            send_byte(junk, $urandom_range(0, 4));
         end
         build_frame({6'($urandom), 2'b00}, 8'($urandom_range(0, 12)),
                     $urandom_range(0, 3) == 0);
         stall = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, frame_q.size() - 1)) : -1;
         send_queue(5, stall);
         repeat (4) @(negedge clk);
      end
      repeat (TO + 5) @(negedge clk);

      // asynchronous reset in the middle of DATA
      build_frame(8'h00, 8'h03, 1'b0);
      for (int i = 0; i < 10; i++) send_byte(frame_q[i], 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst mem_we", 32'(mem_we), 0);
      check("arst mem_addr", 32'(mem_addr), 0);
      check("arst mem_data", 32'(mem_data), 0);
      check("arst cpu_reset", 32'(cpu_reset), 0);
      check("arst busy", 32'(busy), 0);
      check("arst done", 32'(done), 0);
      check("arst error", 32'(error), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      w0 = wr_count;
      for (int i = 10; i < frame_q.size(); i++)
         send_byte((frame_q[i] == SYNC) ? 8'h00 : frame_q[i], 1);
      repeat (3) @(negedge clk);
      check("arst no writes", wr_count - w0, 0);
      check("arst idle busy", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
